// File: rtl/scan_dispatcher.sv
// scan_dispatcher: buffers laser-scan beam endpoints in a small FIFO and
// launches one Bresenham ray trace per beam over a start/busy handshake.
// Reports end-of-scan with a per-scan traced-beam count.
// Optional feature macro: SCAN_DISPATCHER_STATS_EN adds the stall_count port,
// a saturating count of cycles where a beam was offered while the FIFO was full.
module scan_dispatcher #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               beam_valid,
  input  logic [COORD_W-1:0] beam_x,
  input  logic [COORD_W-1:0] beam_y,
  input  logic               beam_last,
  output logic               beam_ready,
  output logic               ray_start,
  output logic [COORD_W-1:0] ray_x,
  output logic [COORD_W-1:0] ray_y,
  input  logic               ray_busy,
  output logic               scan_done,
  output logic [CNT_W-1:0]   scan_beams
`ifdef SCAN_DISPATCHER_STATS_EN
  ,
  output logic [CNT_W-1:0]   stall_count
`endif
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENTRY_W = 2 * COORD_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t             state;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic               head_last;
  logic               last_r;
  logic [CNT_W-1:0]   beam_cnt;
  logic [CNT_W-1:0]   cnt_inc;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign beam_ready = ~full;
  assign push       = beam_valid & ~full;
  // Pop only when the sequencer is idle and the tracer is free.
  assign pop        = (state == IDLE) & ~empty & ~ray_busy;

  assign head      = mem[rd_ptr];
  assign head_x    = head[ENTRY_W-1 -: COORD_W];
  assign head_y    = head[COORD_W:1];
  assign head_last = head[0];

  // Saturating increment of the per-scan beam counter.
  always_comb begin
    cnt_inc = beam_cnt;
    if (beam_cnt != '1) cnt_inc = beam_cnt + 1'b1;
  end

  // FIFO storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {beam_x, beam_y, beam_last};
  end

  // FIFO pointers and occupancy; simultaneous push/pop keeps occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Launch/drain sequencer with registered handshake and scan reporting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ray_start  <= 1'b0;
      ray_x      <= '0;
      ray_y      <= '0;
      last_r     <= 1'b0;
      scan_done  <= 1'b0;
      scan_beams <= '0;
      beam_cnt   <= '0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            ray_x     <= head_x;
            ray_y     <= head_y;
            last_r    <= head_last;
            ray_start <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (ray_busy) begin
            ray_start <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!ray_busy) begin
            state <= IDLE;
            if (last_r) begin
              scan_done  <= 1'b1;
              scan_beams <= cnt_inc;
              beam_cnt   <= '0;
            end else begin
              beam_cnt <= cnt_inc;
            end
          end
        end
        default: begin
          state     <= IDLE;
          ray_start <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCAN_DISPATCHER_STATS_EN
  // Saturating count of offered-but-refused beam cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (beam_valid && !beam_ready && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_scan_dispatcher.sv
// Testbench for scan_dispatcher: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model and a
// behavioural tracer that drives ray_busy.
module tb_scan_dispatcher;

  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int NW    = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          beam_valid;
  logic [CW-1:0] beam_x;
  logic [CW-1:0] beam_y;
  logic          beam_last;
  logic          beam_ready;
  logic          ray_start;
  logic [CW-1:0] ray_x;
  logic [CW-1:0] ray_y;
  logic          ray_busy;
  logic          scan_done;
  logic [NW-1:0] scan_beams;
`ifdef SCAN_DISPATCHER_STATS_EN
  logic [NW-1:0] stall_count;
`endif

  always #5 clock = ~clock;

  scan_dispatcher #(.DEPTH(DEPTH), .COORD_W(CW), .CNT_W(NW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .beam_valid (beam_valid),
    .beam_x     (beam_x),
    .beam_y     (beam_y),
    .beam_last  (beam_last),
    .beam_ready (beam_ready),
    .ray_start  (ray_start),
    .ray_x      (ray_x),
    .ray_y      (ray_y),
    .ray_busy   (ray_busy),
    .scan_done  (scan_done),
    .scan_beams (scan_beams)
`ifdef SCAN_DISPATCHER_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          last;
  } beam_t;

  // Reference model state
  beam_t         q[$];
  bit            m_free;
  bit            e_start;
  logic [CW-1:0] e_x;
  logic [CW-1:0] e_y;
  bit            cur_last;
  int            traced;
  bit            e_done;
  logic [NW-1:0] e_beams;
  int            stall_m;

  // Behavioural tracer state
  int t_phase;
  int t_stall_left;
  int t_busy_left;
  int cfg_stall;
  int cfg_busy;
  bit cfg_rand;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_stall();
    return cfg_rand ? int'($urandom_range(0, 3)) : cfg_stall;
  endfunction

  function automatic int next_busy();
    return cfg_rand ? int'($urandom_range(1, 5)) : cfg_busy;
  endfunction

  task automatic model_reset();
    q.delete();
    m_free   = 1'b1;
    e_start  = 1'b0;
    e_x      = '0;
    e_y      = '0;
    cur_last = 1'b0;
    traced   = 0;
    e_done   = 1'b0;
    e_beams  = '0;
    stall_m  = 0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "beam_ready"}, beam_ready, (q.size() < DEPTH));
    chk({pfx, "ray_start"},  ray_start,  e_start);
    chk({pfx, "ray_x"},      ray_x,      e_x);
    chk({pfx, "ray_y"},      ray_y,      e_y);
    chk({pfx, "scan_done"},  scan_done,  e_done);
    chk({pfx, "scan_beams"}, scan_beams, e_beams);
`ifdef SCAN_DISPATCHER_STATS_EN
    chk({pfx, "stall_count"}, stall_count, stall_m);
`endif
  endtask

  function automatic bit will_pop();
    return reset_n && m_free && (q.size() > 0) && !ray_busy;
  endfunction

  // One clock cycle: decide model transitions from this cycle's inputs,
  // advance, check all outputs, then let the tracer react for the next cycle.
  task automatic tick();
    bit    do_push, do_pop, do_ack, do_end, do_stall;
    beam_t nb;
    beam_t h;
    do_push  = reset_n && beam_valid && (q.size() < DEPTH);
    do_pop   = will_pop();
    do_ack   = reset_n && e_start && ray_busy;
    do_end   = reset_n && !m_free && !e_start && !ray_busy;
    do_stall = reset_n && beam_valid && (q.size() == DEPTH);
    nb.x = beam_x; nb.y = beam_y; nb.last = beam_last;
    @(posedge clock);
    #1;
    e_done = 1'b0;
    if (do_pop) begin
      h        = q.pop_front();
      e_x      = h.x;
      e_y      = h.y;
      cur_last = h.last;
      e_start  = 1'b1;
      m_free   = 1'b0;
    end
    if (do_push) q.push_back(nb);
    if (do_ack) e_start = 1'b0;
    if (do_end) begin
      m_free = 1'b1;
      if (traced < 65535) traced++;
      if (cur_last) begin
        e_done  = 1'b1;
        e_beams = NW'(traced);
        traced  = 0;
      end
    end
    if (do_stall && stall_m < 65535) stall_m++;
    check_outputs("cyc_");
    // tracer: waits t_stall_left cycles after seeing ray_start, then busy
    if (t_phase == 0) begin
      if (e_start) begin
        if (t_stall_left > 0) begin
          t_stall_left--;
          ray_busy = 1'b0;
        end else begin
          t_phase     = 1;
          t_busy_left = next_busy();
          ray_busy    = 1'b1;
        end
      end else begin
        ray_busy = 1'b0;
      end
    end else begin
      t_busy_left--;
      if (t_busy_left <= 0) begin
        ray_busy     = 1'b0;
        t_phase      = 0;
        t_stall_left = next_stall();
      end
    end
  endtask

  task automatic push_beam(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic last);
    beam_valid = 1'b1;
    beam_x     = x;
    beam_y     = y;
    beam_last  = last;
    tick();
    beam_valid = 1'b0;
  endtask

  task automatic run_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    beam_valid = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (q.size() == 0) && m_free && (t_phase == 0) && !ray_busy;
    end
    chk({tag, "_drained"}, done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    beam_valid = 1'b0;
    beam_x     = '0;
    beam_y     = '0;
    beam_last  = 1'b0;
    ray_busy   = 1'b0;
    t_phase    = 0;
    cfg_rand   = 1'b0;
    cfg_stall  = 0;
    cfg_busy   = 5;
    t_stall_left = 0;
    model_reset();

    // Reset state
    #2;
    check_outputs("rst_");
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single beam, tracer busy 5 cycles
    cfg_stall = 0; cfg_busy = 5; t_stall_left = 0;
    push_beam(8'd10, 8'd20, 1'b1);
    run_idle("single", 50);
    chk("single_scan_beams", scan_beams, 16'd1);

    // Three-beam scan, then next scan restarts at 1
    cfg_busy = 4;
    push_beam(8'd1, 8'd2, 1'b0);
    push_beam(8'd3, 8'd4, 1'b0);
    push_beam(8'd5, 8'd6, 1'b1);
    run_idle("three", 100);
    chk("three_scan_beams", scan_beams, 16'd3);
    push_beam(8'd7, 8'd8, 1'b1);
    run_idle("restart", 50);
    chk("restart_scan_beams", scan_beams, 16'd1);

    // Tracer stalls start for 6 cycles
    cfg_stall = 6; cfg_busy = 3; t_stall_left = 6;
    push_beam(8'd9, 8'd11, 1'b1);
    run_idle("stall", 60);
    cfg_stall = 0; t_stall_left = 0;

    // Fill FIFO while the tracer is stuck busy
    cfg_busy = 40;
    push_beam(8'd100, 8'd200, 1'b0);
    for (int i = 0; i < 20 && q.size() < DEPTH; i++) begin
      push_beam(8'(101 + i), 8'(201 + i), 1'b0);
    end
    for (int i = 0; i < 3; i++) push_beam(8'(150 + i), 8'd0, 1'b1);
    chk("full_beam_ready", beam_ready, 1'b0);
`ifdef SCAN_DISPATCHER_STATS_EN
    chk("full_stall_count", stall_count, 16'd3);
`endif
    cfg_busy = 2;
    run_idle("full", 400);

    // Reset while in DRAIN with 4 beams queued
    cfg_busy = 20;
    for (int i = 0; i < 5; i++) push_beam(8'(30 + i), 8'(40 + i), 1'b1);
    for (int i = 0; i < 20 && !(!m_free && !e_start); i++) tick();
    chk("rst_in_drain", (!m_free && !e_start), 1'b1);
    chk("rst_queued", q.size(), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst_");
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    // Simultaneous push and pop at occupancy 1
    cfg_busy = 6;
    push_beam(8'd50, 8'd51, 1'b0);
    push_beam(8'd52, 8'd53, 1'b0);
    for (int i = 0; i < 30 && !will_pop(); i++) tick();
    chk("pp_ready_to_pop", will_pop(), 1'b1);
    push_beam(8'd54, 8'd55, 1'b1);
    chk("pp_launch_x", ray_x, 8'd52);
    chk("pp_launch_start", ray_start, 1'b1);
    run_idle("pp", 80);
    chk("pp_scan_beams", scan_beams, 16'd3);

    // Randomized traffic
    cfg_rand = 1'b1;
    t_stall_left = next_stall();
    for (int i = 0; i < 500; i++) begin
      beam_valid = ($urandom_range(0, 2) == 0);
      beam_x     = CW'($urandom);
      beam_y     = CW'($urandom);
      beam_last  = ($urandom_range(0, 4) == 0);
      tick();
    end
    run_idle("rand", 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
